// File: rtl/noc_pkg.sv
// Shared router constants: output-port codes, the "no flit" code and the port count.
package noc_pkg;

  localparam int N_PORT = 5;

  localparam logic [2:0] PORT_L       = 3'b000;
  localparam logic [2:0] PORT_E       = 3'b001;
  localparam logic [2:0] PORT_W       = 3'b010;
  localparam logic [2:0] PORT_N       = 3'b011;
  localparam logic [2:0] PORT_S       = 3'b100;
  localparam logic [2:0] NOT_REGISTER = 3'b111;

  // Input-controller index (0 L, 1 E, 2 W, 3 N, 4 S) to its port code.
  function automatic logic [2:0] port_code(input int idx);
    logic [2:0] code;
    case (idx)
      0:       code = PORT_L;
      1:       code = PORT_E;
      2:       code = PORT_W;
      3:       code = PORT_N;
      4:       code = PORT_S;
      default: code = NOT_REGISTER;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searched upward from ptr with wrap.
// No grant while enable is low; ptr moves to winner+1 only on a grant.
module rr_arbiter #(
  parameter int N_PORT = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_PORT-1:0] req,
  input  logic              enable,
  output logic [N_PORT-1:0] grant
);

  localparam int PTR_W = (N_PORT > 1) ? $clog2(N_PORT) : 1;

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] win;
  logic [PTR_W-1:0] idx;
  logic [PTR_W:0]   sum;
  logic             found;

  always_comb begin
    grant = '0;
    ptr_d = ptr_q;
    win   = '0;
    idx   = '0;
    sum   = '0;
    found = 1'b0;
    for (int off = 0; off < N_PORT; off++) begin
      sum = {1'b0, ptr_q} + (PTR_W+1)'(off);
      if (sum >= (PTR_W+1)'(N_PORT)) sum = sum - (PTR_W+1)'(N_PORT);
      idx = sum[PTR_W-1:0];
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    if (found && enable) begin
      grant[win] = 1'b1;
      ptr_d      = (win == PTR_W'(N_PORT-1)) ? '0 : win + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/output_controller.sv
// Router output port: claims flits coded for PORT_CODE, grants round-robin into a 2-entry queue,
// and writes the head downstream 1 cycle after grant at the earliest; full stalls writes and grants stop at 2 queued.
module output_controller
  import noc_pkg::*;
#(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    N_REGISTER = 3,
  parameter int                    N_PORT     = 5,
  parameter logic [N_REGISTER-1:0] PORT_CODE  = PORT_L
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_PORT*N_REGISTER-1:0] register,
  input  logic [N_PORT*DATA_WIDTH-1:0] Data_in,
  input  logic                         full,
  output logic [N_PORT-1:0]            grant,
  output logic                         write,
  output logic [DATA_WIDTH-1:0]        Data_out
);

  logic [N_PORT-1:0]     mask_q, mask_d;
  logic                  head_q, head_d;
  logic                  tail_q, tail_d;
  logic [1:0]            count_q, count_d;
  logic [DATA_WIDTH-1:0] mem_q [2];
  logic [DATA_WIDTH-1:0] mem_d [2];

  logic [N_PORT-1:0]     req;
  logic [N_REGISTER-1:0] sel;
  logic [DATA_WIDTH-1:0] win_dat;
  logic                  pop, push, can_push, arb_en;

  // Masking last cycle's winner gives its input controller a cycle to refresh register/Data_in.
  always_comb begin
    req = '0;
    sel = '0;
    for (int i = 0; i < N_PORT; i++) begin
      sel    = register[i*N_REGISTER +: N_REGISTER];
      req[i] = (sel == PORT_CODE) && (sel != N_REGISTER'(NOT_REGISTER)) && !mask_q[i];
    end
  end

  assign pop      = (count_q != 2'd0) && !full;
  assign can_push = (count_q != 2'd2) || pop;
  // Holding enable low during reset keeps grant at zero while the flops are cleared.
  assign arb_en   = can_push && !rst;

  rr_arbiter #(.N_PORT(N_PORT)) u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .enable (arb_en),
    .grant  (grant)
  );

  assign push = |grant;

  always_comb begin
    win_dat = '0;
    for (int i = 0; i < N_PORT; i++) begin
      if (grant[i]) win_dat = Data_in[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    mem_d  = mem_q;
    mask_d = grant;
    tail_d = tail_q ^ push;
    head_d = head_q ^ pop;
    if (push) mem_d[tail_q] = win_dat;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  assign write    = pop;
  assign Data_out = (count_q != 2'd0) ? mem_q[head_q] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_q   <= '0;
      head_q   <= 1'b0;
      tail_q   <= 1'b0;
      count_q  <= 2'd0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      mask_q  <= mask_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

endmodule

// File: tb/tb_output_controller.sv
// Self-checking bench for output_controller serving the E port (code 001).
module tb_output_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [14:0] register;
  logic [39:0] Data_in;
  logic        full;
  logic [4:0]  grant;
  logic        write;
  logic [7:0]  Data_out;

  int          checks   = 0;
  int          failures = 0;
  logic [7:0]  sb [$];
  logic [7:0]  exp_dat;

  output_controller #(
    .DATA_WIDTH (8),
    .N_REGISTER (3),
    .N_PORT     (5),
    .PORT_CODE  (3'b001)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .register (register),
    .Data_in  (Data_in),
    .full     (full),
    .grant    (grant),
    .write    (write),
    .Data_out (Data_out)
  );

  always #5 clk = ~clk;

  // Scoreboard: granted flit captured at grant, compared when written out.
  always @(negedge clk) begin
    if (!rst) begin
      if (write) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected_write: Data_out=%h with empty scoreboard", Data_out);
        end else begin
          exp_dat = sb.pop_front();
          if (Data_out !== exp_dat) begin
            failures++;
            $display("FAIL sb_order: Data_out=%h expected=%h", Data_out, exp_dat);
          end
        end
      end
      if (grant != 5'b0) begin
        checks++;
        if (!$onehot(grant)) begin
          failures++;
          $display("FAIL grant_onehot: grant=%b", grant);
        end
        for (int i = 0; i < 5; i++) if (grant[i]) sb.push_back(Data_in[i*8 +: 8]);
      end
    end
  end

  task automatic set_codes(input logic [2:0] c0, c1, c2, c3, c4);
    register = {c4, c3, c2, c1, c0};
  endtask

  task automatic set_data_base(input logic [7:0] base);
    for (int i = 0; i < 5; i++) Data_in[i*8 +: 8] = base + 8'(i);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    sb.delete();
    tick();
    rst = 1'b0;
  endtask

  // Removes all requests and waits (bounded) for the queue to empty.
  task automatic drain(output int nwrites);
    bit done = 0;
    nwrites = 0;
    set_codes(3'b111, 3'b111, 3'b111, 3'b111, 3'b111);
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (write) nwrites++;
      else if (sb.size() == 0) begin
        done = 1;
        break;
      end
      tick();
    end
    tick();
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL drain_timeout: sb_size=%0d expected 0 within 8 cycles", sb.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    full = 1'b0;
    Data_in = '0;
    set_codes(3'b111, 3'b111, 3'b111, 3'b111, 3'b111);
    #3;
    checks++;
    if (grant !== 5'b0 || write !== 1'b0 || Data_out !== 8'h00) begin
      failures++;
      $display("FAIL reset_outputs: grant=%b write=%b Data_out=%h expected 0/0/00", grant, write, Data_out);
    end
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_single();
    int nw;
    pulse_reset();
    full = 1'b0;
    Data_in = '0;
    Data_in[16 +: 8] = 8'hA5;
    set_codes(3'b111, 3'b111, 3'b001, 3'b111, 3'b111);
    @(negedge clk);
    checks++;
    if (grant !== 5'b00100 || write !== 1'b0) begin
      failures++;
      $display("FAIL single_grant: grant=%b write=%b expected 00100/0", grant, write);
    end
    tick();
    @(negedge clk);
    checks++;
    if (grant !== 5'b0 || write !== 1'b1 || Data_out !== 8'hA5) begin
      failures++;
      $display("FAIL single_mask_write: grant=%b write=%b Data_out=%h expected 00000/1/a5", grant, write, Data_out);
    end
    tick();
    drain(nw);
  endtask

  task automatic test_rotate();
    int nw;
    logic [4:0] eg;
    pulse_reset();
    full = 1'b0;
    set_data_base(8'h10);
    set_codes(3'b001, 3'b001, 3'b001, 3'b001, 3'b001);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      eg = 5'b00001 << (c % 5);
      checks++;
      if (grant !== eg) begin
        failures++;
        $display("FAIL rotate_grant[%0d]: grant=%b expected %b", c, grant, eg);
      end
      if (c > 0) begin
        checks++;
        if (write !== 1'b1 || Data_out !== 8'h10 + 8'((c - 1) % 5)) begin
          failures++;
          $display("FAIL rotate_write[%0d]: write=%b Data_out=%h expected 1/%h", c, write, Data_out, 8'h10 + 8'((c - 1) % 5));
        end
      end
      tick();
    end
    drain(nw);
  endtask

  task automatic test_full();
    int nw;
    logic [4:0] eg;
    pulse_reset();
    set_data_base(8'h10);
    full = 1'b1;
    set_codes(3'b001, 3'b111, 3'b111, 3'b001, 3'b111);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      eg = (c == 0) ? 5'b00001 : (c == 1) ? 5'b01000 : 5'b00000;
      checks++;
      if (grant !== eg || write !== 1'b0) begin
        failures++;
        $display("FAIL full_stall[%0d]: grant=%b write=%b expected %b/0", c, grant, write, eg);
      end
      if (c >= 2) begin
        checks++;
        if (Data_out !== 8'h10) begin
          failures++;
          $display("FAIL full_head_hold[%0d]: Data_out=%h expected 10", c, Data_out);
        end
      end
      tick();
    end
    set_codes(3'b111, 3'b111, 3'b111, 3'b111, 3'b111);
    full = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (write !== 1'b1 || Data_out !== ((c == 0) ? 8'h10 : 8'h13)) begin
        failures++;
        $display("FAIL full_release[%0d]: write=%b Data_out=%h expected 1/%h", c, write, Data_out, (c == 0) ? 8'h10 : 8'h13);
      end
      tick();
    end
    drain(nw);
  endtask

  task automatic test_back_to_back();
    int nw;
    logic [4:0] seq = 5'd0;
    pulse_reset();
    full = 1'b1;
    set_codes(3'b001, 3'b111, 3'b111, 3'b001, 3'b111);
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < 5; i++) Data_in[i*8 +: 8] = {3'(i), seq};
      seq++;
      if (c == 2) begin
        @(negedge clk);
        checks++;
        if (grant !== 5'b0) begin
          failures++;
          $display("FAIL b2b_fill: grant=%b expected 00000 with queue full", grant);
        end
      end
      tick();
    end
    full = 1'b0;
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < 5; i++) Data_in[i*8 +: 8] = {3'(i), seq};
      seq++;
      @(negedge clk);
      checks++;
      if (write !== 1'b1 || grant == 5'b0) begin
        failures++;
        $display("FAIL b2b_stream[%0d]: write=%b grant=%b expected 1/nonzero", c, write, grant);
      end
      tick();
    end
    drain(nw);
    checks++;
    if (nw != 2) begin
      failures++;
      $display("FAIL b2b_residual: writes_after_stop=%0d expected 2", nw);
    end
  endtask

  task automatic test_other_codes();
    logic [2:0] pick [3];
    logic [2:0] c [5];
    pick[0] = 3'b000;
    pick[1] = 3'b010;
    pick[2] = 3'b111;
    full = 1'b0;
    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < 5; i++) c[i] = pick[$urandom_range(0, 2)];
      set_codes(c[0], c[1], c[2], c[3], c[4]);
      Data_in = {$urandom, 8'($urandom)};
      @(negedge clk);
      checks++;
      if (grant !== 5'b0 || write !== 1'b0 || Data_out !== 8'h00) begin
        failures++;
        $display("FAIL other_codes[%0d]: grant=%b write=%b Data_out=%h expected 0/0/00", n, grant, write, Data_out);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    int nw;
    pulse_reset();
    set_data_base(8'h10);
    full = 1'b1;
    set_codes(3'b001, 3'b111, 3'b111, 3'b001, 3'b111);
    tick();
    tick();
    full = 1'b0;
    #1;
    checks++;
    if (write !== 1'b1 || Data_out !== 8'h10) begin
      failures++;
      $display("FAIL mid_pre_reset: write=%b Data_out=%h expected 1/10", write, Data_out);
    end
    rst = 1'b1;
    sb.delete();
    #1;
    checks++;
    if (grant !== 5'b0 || write !== 1'b0 || Data_out !== 8'h00) begin
      failures++;
      $display("FAIL mid_async_reset: grant=%b write=%b Data_out=%h expected 0/0/00", grant, write, Data_out);
    end
    tick();
    rst = 1'b0;
    set_data_base(8'h20);
    @(negedge clk);
    checks++;
    if (grant !== 5'b00001) begin
      failures++;
      $display("FAIL mid_ptr_restart: grant=%b expected 00001", grant);
    end
    tick();
    drain(nw);
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotate();
    test_full();
    test_back_to_back();
    test_other_codes();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover: entries=%0d expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
